// File: rtl/mysystem_rom_reader_pkg.sv
// Shared types and widths for the ROM block reader.
// Holds the FSM state enum and the address/data/count widths.
package mysystem_rom_reader_pkg;

  localparam int ROM_AW = 14;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mysystem_rom_reader_fifo.sv
// Show-ahead FIFO for the ROM reader output stream.
// Ports: clk/reset, wr_en/wr_data, rd_en/rd_data/valid, level.
module mysystem_rom_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          pop;

  assign valid = (cnt != '0);
  assign pop   = rd_en && valid;
  assign level = cnt;

  // Gated so the stream reads 0 whenever nothing is buffered.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + LW'(wr_en) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mysystem_rom_reader.sv
// Streams a contiguous block of ROM words onto a valid/ready stream.
// Ports: start/base_addr/word_count in, busy/done/checksum out, ROM read port, out stream.
module mysystem_rom_reader
  import mysystem_rom_reader_pkg::*;
#(
  parameter int MEM_DEPTH  = 10240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ROM_AW-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(MEM_DEPTH - 1);

  state_t            state;
  logic [ROM_AW-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  issued;
  logic              in_flight;
  logic [LW-1:0]     level;
  logic              credit;
  logic              issue;
  logic              last_issue;
  logic              pop;
  logic              drained;

  // Space for the word already in flight plus this one; a pop in the
  // same cycle is deliberately not counted.
  assign credit = (level + LW'(in_flight)) < LW'(FIFO_DEPTH);

  assign issue      = (state == RUN) && (issued != count) && credit;
  assign last_issue = issue && (issued == count - CNT_W'(1));
  assign pop        = out_valid && out_ready;

  // Looks one edge ahead so done lands the cycle after the final accept.
  assign drained = !in_flight &&
                   ((level == '0) || ((level == LW'(1)) && pop));

  assign rom_address    = addr;
  assign rom_chipselect = issue;
  assign rom_clken      = issue;

  mysystem_rom_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_flight),
    .wr_data (rom_readdata),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .valid   (out_valid),
    .level   (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      issued    <= '0;
      in_flight <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      in_flight <= issue;
      done      <= 1'b0;
      if (pop) checksum <= checksum + out_data;
      if (issue) begin
        addr   <= (addr == LAST_ADDR) ? '0 : addr + ROM_AW'(1);
        issued <= issued + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            addr     <= base_addr;
            count    <= word_count;
            issued   <= '0;
            checksum <= '0;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
